// File: rtl/breakout_pkg.sv
// Breakout shared constants: field widths, timeout default
// and the draw arbiter FSM encodings.
package breakout_pkg;

  localparam int X_W   = 8;
  localparam int Y_W   = 7;
  localparam int COL_W = 3;
  localparam int CNT_W = 12;

  localparam int DEF_TIMEOUT_CYCLES = 4096;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_GRANT   = 2'd1,
    S_BUSY    = 2'd2,
    S_RELEASE = 2'd3
  } arb_state_t;

endpackage

// File: rtl/draw_arbiter_if.sv
// Client request bundle and muxed VGA write port
// of the draw arbiter.
interface draw_arbiter_if #(
  parameter int N_REQ = 3
);
  import breakout_pkg::*;

  logic [N_REQ-1:0]       req;
  logic [N_REQ-1:0]       done_in;
  logic [N_REQ-1:0]       plot_in;
  logic [X_W*N_REQ-1:0]   x_in;
  logic [Y_W*N_REQ-1:0]   y_in;
  logic [COL_W*N_REQ-1:0] colour_in;

  logic [N_REQ-1:0]       grant;
  logic [X_W-1:0]         vga_x;
  logic [Y_W-1:0]         vga_y;
  logic [COL_W-1:0]       vga_colour;
  logic                   vga_plot;
  logic                   busy;
  logic                   timeout_err;

  modport master (
    output req, done_in, plot_in,
    output x_in, y_in, colour_in,
    input  grant, vga_x, vga_y,
    input  vga_colour, vga_plot,
    input  busy, timeout_err
  );

  modport slave (
    input  req, done_in, plot_in,
    input  x_in, y_in, colour_in,
    output grant, vga_x, vga_y,
    output vga_colour, vga_plot,
    output busy, timeout_err
  );

endinterface

// File: rtl/draw_arbiter_rr_pick.sv
// Round-robin winner select: search starts one past
// last_grant and wraps modulo N_REQ.
module rr_pick #(
  parameter int N_REQ = 3,
  parameter int IW    = 2
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IW-1:0]    last_grant,
  output logic [N_REQ-1:0] winner
);

  logic [N_REQ-1:0] one;

  assign one = N_REQ'(1);

  // Walk farthest-first so the nearest requester overwrites.
  always_comb begin
    winner = '0;
    for (int k = N_REQ; k >= 1; k--) begin
      if (req[(int'(last_grant) + k) % N_REQ])
        winner = one << ((int'(last_grant) + k) % N_REQ);
    end
  end

endmodule

// File: rtl/draw_arbiter.sv
// Draw arbiter: shares the VGA write port between the
// paddle, ball and brick drawing clients.
module draw_arbiter
  import breakout_pkg::*;
#(
  parameter int N_REQ          = 3,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic           clock,
  input  logic           reset_state,
  draw_arbiter_if.slave  bus
);

  localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  arb_state_t state, state_nx;

  logic [N_REQ-1:0] win;
  logic [N_REQ-1:0] grant_q;
  logic [IW-1:0]    win_idx;
  logic [IW-1:0]    g_idx;
  logic [IW-1:0]    last_grant;
  logic [CNT_W-1:0] cnt;

  logic             in_busy;
  logic             to_hit;
  logic             g_req;
  logic             g_done;
  logic             g_plot;
  logic [X_W-1:0]   g_x;
  logic [Y_W-1:0]   g_y;
  logic [COL_W-1:0] g_col;

  rr_pick #(
    .N_REQ (N_REQ),
    .IW    (IW)
  ) u_pick (
    .req        (bus.req),
    .last_grant (last_grant),
    .winner     (win)
  );

  always_comb begin
    win_idx = '0;
    for (int i = 0; i < N_REQ; i++)
      if (win[i]) win_idx = IW'(i);
  end

  // Only the granted client's signals ever reach the FSM or port.
  always_comb begin
    g_req  = 1'b0;
    g_done = 1'b0;
    g_plot = 1'b0;
    g_x    = '0;
    g_y    = '0;
    g_col  = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (IW'(i) == g_idx) begin
        g_req  = bus.req[i];
        g_done = bus.done_in[i];
        g_plot = bus.plot_in[i];
        g_x    = bus.x_in[i*X_W +: X_W];
        g_y    = bus.y_in[i*Y_W +: Y_W];
        g_col  = bus.colour_in[i*COL_W +: COL_W];
      end
    end
  end

  assign in_busy = (state == S_BUSY);
  assign to_hit  = (cnt == CNT_W'(TIMEOUT_CYCLES - 1));

  always_comb begin
    state_nx = state;
    unique case (state)
      S_IDLE:    if (|bus.req) state_nx = S_GRANT;
      S_GRANT:   state_nx = S_BUSY;
      S_BUSY:
        if (g_done || !g_req || to_hit)
          state_nx = S_RELEASE;
      S_RELEASE: state_nx = S_IDLE;
      default:   state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_state) begin
    if (!reset_state) begin
      state      <= S_IDLE;
      grant_q    <= '0;
      g_idx      <= '0;
      last_grant <= IW'(N_REQ - 1);
      cnt        <= '0;
    end else begin
      state <= state_nx;
      unique case (state)
        S_IDLE:
          if (|bus.req) begin
            grant_q <= win;
            g_idx   <= win_idx;
          end
        S_GRANT: cnt <= '0;
        S_BUSY: begin
          cnt <= cnt + 1'b1;
          if (state_nx == S_RELEASE) grant_q <= '0;
        end
        S_RELEASE: last_grant <= g_idx;
        default: ;
      endcase
    end
  end

  // Done on the timeout cycle wins: no error.
  assign bus.timeout_err = in_busy && to_hit && !g_done;

  assign bus.grant      = grant_q;
  assign bus.busy       = (state == S_GRANT) || in_busy;
  assign bus.vga_plot   = in_busy && g_plot;
  assign bus.vga_x      = in_busy ? g_x   : '0;
  assign bus.vga_y      = in_busy ? g_y   : '0;
  assign bus.vga_colour = in_busy ? g_col : '0;

endmodule

// File: tb/tb_draw_arbiter.sv
// Directed self-checking bench for draw_arbiter.
// Inputs driven and outputs sampled 1 unit after posedge.
module tb_draw_arbiter;

  logic clock;
  logic reset_state;
  int   tests;
  int   fails;
  int   early;

  logic [2:0] exp_seq [4];

  draw_arbiter_if #(.N_REQ(3)) bus ();

  draw_arbiter #(
    .N_REQ          (3),
    .TIMEOUT_CYCLES (4096)
  ) dut (
    .clock       (clock),
    .reset_state (reset_state),
    .bus         (bus)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h",
             tag, obs, exp);
    end
  endtask

  task automatic set_fields(input int i,
                            input logic [7:0] x,
                            input logic [6:0] y,
                            input logic [2:0] c);
    bus.x_in[i*8 +: 8]      = x;
    bus.y_in[i*7 +: 7]      = y;
    bus.colour_in[i*3 +: 3] = c;
  endtask

  initial begin
    tests = 0;
    fails = 0;
    exp_seq[0] = 3'b001;
    exp_seq[1] = 3'b010;
    exp_seq[2] = 3'b100;
    exp_seq[3] = 3'b001;
    reset_state   = 1'b0;
    bus.req       = '0;
    bus.done_in   = '0;
    bus.plot_in   = '0;
    bus.x_in      = '0;
    bus.y_in      = '0;
    bus.colour_in = '0;

    // reset values
    #3;
    chk("rst_grant", bus.grant, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_to", bus.timeout_err, 0);
    chk("rst_plot", bus.vga_plot, 0);
    @(posedge clock);
    #1 reset_state = 1'b1;

    // basic grant and muxing
    tick();
    chk("idle_grant", bus.grant, 0);
    set_fields(0, 8'd140, 7'd100, 3'b111);
    set_fields(1, 8'd55, 7'd20, 3'b010);
    bus.plot_in = 3'b011;
    bus.req     = 3'b001;
    tick();
    chk("g0_grant", bus.grant, 3'b001);
    chk("g0_busy", bus.busy, 1);
    chk("g0_plot_gnt", bus.vga_plot, 0);
    chk("g0_x_gnt", bus.vga_x, 0);
    tick();
    chk("g0_x", bus.vga_x, 140);
    chk("g0_y", bus.vga_y, 100);
    chk("g0_col", bus.vga_colour, 7);
    chk("g0_plot", bus.vga_plot, 1);
    bus.done_in = 3'b001;
    #1 chk("g0_to", bus.timeout_err, 0);
    tick();
    chk("g0_rel_grant", bus.grant, 0);
    chk("g0_rel_busy", bus.busy, 0);
    chk("g0_rel_plot", bus.vga_plot, 0);
    chk("g0_rel_x", bus.vga_x, 0);
    bus.done_in = '0;
    bus.req     = '0;
    bus.plot_in = '0;
    tick();

    // round-robin rotation from reset
    reset_state = 1'b0;
    #2 chk("rst2_grant", bus.grant, 0);
    reset_state = 1'b1;
    bus.req = 3'b111;
    for (int r = 0; r < 4; r++) begin
      tick();
      chk("rr_grant", bus.grant, exp_seq[r]);
      tick();
      bus.done_in = ~exp_seq[r];
      tick();
      chk("rr_ignore", bus.grant, exp_seq[r]);
      bus.done_in = '0;
      tick();
      tick();
      bus.done_in = exp_seq[r];
      tick();
      chk("rr_gap1", bus.grant, 0);
      chk("rr_gap1_to", bus.timeout_err, 0);
      bus.done_in = '0;
      tick();
      chk("rr_gap2", bus.grant, 0);
    end

    // timeout on client 1, then client 2
    bus.req = 3'b110;
    tick();
    chk("to_grant", bus.grant, 3'b010);
    early = 0;
    for (int k = 1; k <= 4095; k++) begin
      tick();
      if (bus.timeout_err !== 1'b0 ||
          bus.grant !== 3'b010)
        early++;
    end
    chk("to_early", early, 0);
    tick();
    chk("to_pulse", bus.timeout_err, 1);
    chk("to_pulse_grant", bus.grant, 3'b010);
    tick();
    chk("to_rel_grant", bus.grant, 0);
    chk("to_rel_to", bus.timeout_err, 0);
    tick();
    tick();
    chk("to_next", bus.grant, 3'b100);

    // abort on client 2, foreign plot ignored
    tick();
    set_fields(2, 8'd33, 7'd5, 3'b001);
    bus.plot_in = 3'b001;
    #1;
    chk("ab_x", bus.vga_x, 33);
    chk("ab_plot", bus.vga_plot, 0);
    bus.req = 3'b010;
    #1 chk("ab_to", bus.timeout_err, 0);
    tick();
    chk("ab_rel_grant", bus.grant, 0);
    chk("ab_rel_to", bus.timeout_err, 0);
    chk("ab_rel_plot", bus.vga_plot, 0);
    bus.plot_in = '0;
    bus.req     = '0;
    tick();

    // async reset mid-BUSY
    bus.req = 3'b001;
    tick();
    chk("mr_grant", bus.grant, 3'b001);
    tick();
    bus.plot_in = 3'b001;
    #1 chk("mr_plot", bus.vga_plot, 1);
    reset_state = 1'b0;
    #1;
    chk("mr_rst_grant", bus.grant, 0);
    chk("mr_rst_plot", bus.vga_plot, 0);
    chk("mr_rst_busy", bus.busy, 0);
    reset_state = 1'b1;
    bus.plot_in = '0;
    bus.req     = 3'b110;
    tick();
    chk("mr_first", bus.grant, 3'b010);

    // done on the timeout cycle: no error
    early = 0;
    for (int k = 1; k <= 4096; k++) begin
      tick();
      if (bus.grant !== 3'b010) early++;
    end
    chk("dt_held", early, 0);
    bus.done_in = 3'b010;
    #1;
    chk("dt_to", bus.timeout_err, 0);
    tick();
    chk("dt_rel_grant", bus.grant, 0);
    chk("dt_rel_to", bus.timeout_err, 0);
    bus.done_in = '0;
    bus.req     = '0;
    tick();

    $display("[TB] %0d tests run, %0d failed",
             tests, fails);
    $finish;
  end

endmodule

// File: doc/draw_arbiter.md
DRAW_ARBITER -- requirements
Module: draw_arbiter

Interface
REQ-001 Parameter: N_REQ, 3, number of drawing clients (0 = paddle, 1 = ball, 2 = bricks).
REQ-002 Parameter: TIMEOUT_CYCLES, 4096, maximum BUSY cycles before forced release; counter width is 12 bits.
REQ-003 The block SHALL use one clock; reset is asynchronous and active-low.
REQ-004 clock  in  1  system clock; all state changes on its rising edge.
REQ-005 reset_state  in  1  asynchronous active-low reset.
REQ-006 req  in  N_REQ  per-client level request for the VGA write port.
REQ-007 done_in  in  N_REQ  per-client single-cycle pulse: drawing pass complete.
REQ-008 plot_in  in  N_REQ  per-client pixel write strobe.
REQ-009 x_in  in  8*N_REQ  packed client x coordinates; client i is bits [8i+7:8i].
REQ-010 y_in  in  7*N_REQ  packed client y coordinates; client i is bits [7i+6:7i].
REQ-011 colour_in  in  3*N_REQ  packed client colours; client i is bits [3i+2:3i].
REQ-012 grant  out  N_REQ  one-hot grant, registered.
REQ-013 vga_x, vga_y, vga_colour, vga_plot  out  8/7/3/1  muxed VGA adapter write port.
REQ-014 busy  out  1  high while in the GRANT or BUSY state.
REQ-015 timeout_err  out  1  single-cycle pulse on a forced release.

Function
REQ-016 The FSM SHALL have four states: IDLE, GRANT, BUSY and RELEASE; the encodings are constants in the shared package.
REQ-017 IDLE: if any req bit is high, the block SHALL select a winner round-robin, searching from last_grant+1 modulo N_REQ, and go to GRANT; otherwise it stays in IDLE.
REQ-018 GRANT: grant is set one-hot to the winner, the timeout counter is cleared, vga_plot is held at 0, and the FSM goes to BUSY; req-to-grant latency is exactly 1 cycle from IDLE.
REQ-019 BUSY: vga_x, vga_y and vga_colour SHALL equal the granted client's fields combinationally, and vga_plot = plot_in[g].
REQ-020 BUSY: the timeout counter increments each cycle.
REQ-021 BUSY exits to RELEASE when any of these holds:
- done_in[g] is high;
- req[g] is low (abort);
- the counter equals TIMEOUT_CYCLES-1; timeout_err pulses in the same cycle.
REQ-022 If done_in[g] and the timeout occur in the same cycle, the exit is treated as done: no timeout_err.
REQ-023 RELEASE: grant is all 0, last_grant is set to g, and the FSM goes to IDLE; done-to-next-grant is therefore a minimum of 3 cycles.
REQ-024 plot_in, done_in and fields from non-granted clients SHALL be ignored in every state.
REQ-025 Outside BUSY: vga_plot = 0 and vga_x, vga_y, vga_colour = 0.
REQ-026 req changes during GRANT SHALL NOT alter the selected winner.
REQ-027 A request held continuously by a client SHALL be granted within N_REQ arbitration rounds (no starvation).

Reset
REQ-028 Asserting reset_state (low) at any time, including mid-BUSY, SHALL immediately force the following reset values:
- state = IDLE, grant = 0, busy = 0, timeout_err = 0;
- counter = 0, last_grant = N_REQ-1, so client 0 wins first.
REQ-029 The first arbitration SHALL occur on the first rising clock edge after reset_state deasserts.

Structure
REQ-030 The shared package breakout_pkg SHALL hold:
- the state encodings;
- X_W=8, Y_W=7, COL_W=3;
- the default TIMEOUT_CYCLES.
REQ-031 The single sub-module rr_pick (combinational: req, last_grant -> one-hot winner) SHALL be instantiated once; all state and counters reside in draw_arbiter.

Verification
REQ-032 Reset, then req=3'b001 -> grant=3'b001 at the 2nd edge; client 0 x=8'd140, y=7'd100, col=3'b111, plot=1 -> vga_x=140, vga_y=100, vga_colour=7, vga_plot=1.
REQ-033 req=3'b111 held, each client pulses done 5 cycles after grant -> grant sequence 001, 010, 100, 001, with grant=0 for exactly 2 cycles between grants.
REQ-034 Client 1 granted and never pulses done -> timeout_err pulses at BUSY cycle 4096, grant=0 the next cycle, then client 2 is granted if it is requesting.
REQ-035 Client 2 granted, req[2] dropped mid-BUSY, and a plot_in[0] pulse during BUSY -> RELEASE, no timeout_err, vga_plot stays 0 for the client 0 pulse.
REQ-036 reset_state pulled low mid-BUSY -> grant=0 and vga_plot=0 with no clock edge; after release, req=3'b110 -> client 1 granted first.
